// File: rtl/bus_pkg.sv
// Shared types and address constants for the CPU bus responder.
package bus_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } resp_state_t;

    localparam logic [15:0] IO_OUT_OFS = 16'd0;
    localparam logic [15:0] IO_IN_OFS  = 16'd1;
    localparam logic [15:0] CYC_OFS    = 16'd2;
    localparam logic [15:0] VEC_LO     = 16'hFFFC;
    localparam logic [15:0] VEC_HI     = 16'hFFFD;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous-read RAM, 2^AW x 8, read-before-write on the same edge.
module ram_sp #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [0:(1<<AW)-1];

    // NOTE: storage has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: RAM / I/O / reset-vector decode with a one-cycle rdy strobe.
// Wait states are only built when RESP_WAITSTATE_EN is defined; otherwise latency is fixed at 1.
module bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned RAM_AW      = 11,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [15:0] IO_BASE     = 16'h4000,
    parameter logic [15:0] RESET_VEC   = 16'h0200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        mem_rw,
    input  logic [7:0]  wdata,
    input  logic [7:0]  io_in,
    output logic [7:0]  rdata,
    output logic        rdy,
    output logic        bus_err,
    output logic [7:0]  io_out
);

    localparam logic [15:0] A_IO_OUT = IO_BASE + IO_OUT_OFS;
    localparam logic [15:0] A_IO_IN  = IO_BASE + IO_IN_OFS;
    localparam logic [15:0] A_CYC    = IO_BASE + CYC_OFS;

    resp_state_t state_q, state_d;

    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [7:0]  io_out_q;
    logic [7:0]  cyc_cnt_q;
    logic [7:0]  cyc_snap_q;
    logic [7:0]  sync1_q, sync2_q;

    logic        accept;
    logic        ram_we;
    logic        io_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]  ram_rdata;

    logic [7:0]  resp_data;
    logic        resp_err;
    logic        ram_wr_sel;
    logic        io_wr_sel;

    assign accept = (state_q == R_IDLE) && req;

`ifdef RESP_WAITSTATE_EN
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [3:0] wait_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 4'd0;
        end else if (accept) begin
            wait_cnt_q <= WAIT_LOAD;
        end else if (state_q == R_WAIT && wait_cnt_q != 4'd0) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            R_IDLE: begin
                if (req) begin
`ifdef RESP_WAITSTATE_EN
                    state_d = (WAIT_CYCLES == 0) ? R_RESP : R_WAIT;
`else
                    state_d = R_RESP;
`endif
                end
            end
            R_WAIT: begin
`ifdef RESP_WAITSTATE_EN
                if (wait_cnt_q == 4'd0) begin
                    state_d = R_RESP;
                end
`else
                state_d = R_IDLE;
`endif
            end
            R_RESP:  state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rdy     = (state_q == R_RESP);
        rdata   = rdy ? resp_data : 8'h00;
        bus_err = rdy && resp_err;
        ram_we  = rdy && ram_wr_sel;
        io_we   = rdy && io_wr_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= 16'h0000;
            rw_q       <= 1'b1;
            wdata_q    <= 8'h00;
            cyc_snap_q <= 8'h00;
        end else if (accept) begin
            addr_q     <= addr;
            rw_q       <= mem_rw;
            wdata_q    <= wdata;
            cyc_snap_q <= cyc_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= 8'h00;
            sync1_q   <= 8'h00;
            sync2_q   <= 8'h00;
            io_out_q  <= 8'h00;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 8'd1;
            sync1_q   <= io_in;
            sync2_q   <= sync1_q;
            if (io_we) begin
                io_out_q <= wdata_q;
            end
        end
    end

    assign io_out = io_out_q;

    // NOTE: defaults first in every combinational block so no path leaves a signal unassigned (no latches).
    always_comb begin
        resp_data  = 8'hFF;
        resp_err   = 1'b1;
        ram_wr_sel = 1'b0;
        io_wr_sel  = 1'b0;
        if ((addr_q >> RAM_AW) == 16'd0) begin
            resp_data  = ram_rdata;
            resp_err   = 1'b0;
            ram_wr_sel = !rw_q;
        end else if (addr_q == A_IO_OUT) begin
            resp_data = io_out_q;
            resp_err  = 1'b0;
            io_wr_sel = !rw_q;
        end else if (addr_q == A_IO_IN) begin
            resp_data = sync2_q;
            resp_err  = !rw_q;
        end else if (addr_q == A_CYC) begin
            resp_data = cyc_snap_q;
            resp_err  = !rw_q;
        end else if (addr_q == VEC_LO) begin
            resp_data = RESET_VEC[7:0];
            resp_err  = !rw_q;
        end else if (addr_q == VEC_HI) begin
            resp_data = RESET_VEC[15:8];
            resp_err  = !rw_q;
        end
    end

    // The read is launched from the live address at accept; commits use the captured one.
    assign ram_addr = (state_q == R_IDLE) ? addr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];

    ram_sp #(
        .AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder; expected latency follows RESP_WAITSTATE_EN.
module tb_bus_responder;

    localparam int W = 1;
`ifdef RESP_WAITSTATE_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = 1;
`endif
    localparam int PER = LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [15:0] addr;
    logic        mem_rw;
    logic [7:0]  wdata;
    logic [7:0]  io_in;
    logic [7:0]  rdata;
    logic        rdy;
    logic        bus_err;
    logic [7:0]  io_out;

    int n_cmp = 0;
    int n_bad = 0;

    bus_responder #(
        .RAM_AW      (11),
        .WAIT_CYCLES (W),
        .IO_BASE     (16'h4000),
        .RESET_VEC   (16'h0200)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .addr    (addr),
        .mem_rw  (mem_rw),
        .wdata   (wdata),
        .io_in   (io_in),
        .rdata   (rdata),
        .rdy     (rdy),
        .bus_err (bus_err),
        .io_out  (io_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; lat is the cycle index (1 = cycle after accept) in which rdy was seen, 0 on timeout.
    task automatic xfer(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                        output logic [7:0] rd, output logic err, output int lat);
        @(negedge clk);
        req = 1'b1; addr = a; mem_rw = rw; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0; rd = 8'hxx; err = 1'bx;
        for (int j = 1; j <= 40; j++) begin
            if (rdy) begin
                lat = j; rd = rdata; err = bus_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
        end
    endtask

    logic [7:0] rd, c1, c2;
    logic       er;
    int         lat;
    int         pulses, first_k, second_k, bad_data;

    initial begin
        rst_n = 1'b0; req = 1'b0; addr = 16'h0; mem_rw = 1'b1; wdata = 8'h0; io_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rdy", 16'(rdy), 16'h0);
        check("rst_err", 16'(bus_err), 16'h0);
        check("rst_io_out", 16'(io_out), 16'h00);
        check("rst_rdata", 16'(rdata), 16'h00);
        rst_n = 1'b1;

        xfer(16'h0010, 1'b0, 8'h5A, rd, er, lat);
        check("ram_wr_lat", 16'(lat), 16'(LAT));
        check("ram_wr_err", 16'(er), 16'h0);
        xfer(16'h0010, 1'b1, 8'h00, rd, er, lat);
        check("ram_rd_data", 16'(rd), 16'h5A);
        check("ram_rd_lat", 16'(lat), 16'(LAT));
        check("ram_rd_err", 16'(er), 16'h0);

        xfer(16'hFFFC, 1'b1, 8'h00, rd, er, lat);
        check("vec_lo", 16'(rd), 16'h00);
        xfer(16'hFFFD, 1'b1, 8'h00, rd, er, lat);
        check("vec_hi", 16'(rd), 16'h02);
        check("vec_hi_err", 16'(er), 16'h0);
        xfer(16'hFFFC, 1'b0, 8'h99, rd, er, lat);
        check("vec_wr_err", 16'(er), 16'h1);
        xfer(16'hFFFD, 1'b1, 8'h00, rd, er, lat);
        check("vec_hi_after_wr", 16'(rd), 16'h02);

        xfer(16'h4000, 1'b0, 8'hA5, rd, er, lat);
        check("io_out_val", 16'(io_out), 16'hA5);
        check("io_out_wr_err", 16'(er), 16'h0);
        xfer(16'h4000, 1'b1, 8'h00, rd, er, lat);
        check("io_out_rd", 16'(rd), 16'hA5);

        @(negedge clk);
        io_in = 8'h3C;
        repeat (2) @(posedge clk);
        xfer(16'h4001, 1'b1, 8'h00, rd, er, lat);
        check("io_in_rd", 16'(rd), 16'h3C);
        check("io_in_rd_err", 16'(er), 16'h0);
        xfer(16'h4001, 1'b0, 8'h11, rd, er, lat);
        check("io_in_wr_err", 16'(er), 16'h1);

        xfer(16'h9000, 1'b1, 8'h00, rd, er, lat);
        check("unmapped_data", 16'(rd), 16'hFF);
        check("unmapped_err", 16'(er), 16'h1);
        check("err_one_cycle", 16'(bus_err), 16'h0);
        check("rdata_idle_zero", 16'(rdata), 16'h00);

        // Back-to-back CYC reads: accepts are exactly PER edges apart.
        xfer(16'h4002, 1'b1, 8'h00, c1, er, lat);
        xfer(16'h4002, 1'b1, 8'h00, c2, er, lat);
        check("cyc_delta", 16'(c2 - c1), 16'(PER));

        // Continuous request: one rdy every PER cycles.
        @(negedge clk);
        req = 1'b1; addr = 16'h0010; mem_rw = 1'b1;
        pulses = 0; first_k = -1; second_k = -1; bad_data = 0;
        for (int k = 0; k < 4 * PER; k++) begin
            @(posedge clk); #1;
            if (rdy) begin
                if (pulses == 0) first_k = k;
                if (pulses == 1) second_k = k;
                if (rdata !== 8'h5A) bad_data++;
                pulses++;
            end
        end
        req = 1'b0;
        check("stream_pulses", 16'(pulses), 16'd4);
        check("stream_first", 16'(first_k), 16'(LAT - 1));
        check("stream_period", 16'(second_k - first_k), 16'(PER));
        check("stream_data", 16'(bad_data), 16'd0);
        repeat (PER) @(posedge clk);

        // Reset mid-write: no rdy afterwards, no commit, io_out cleared.
        xfer(16'h0020, 1'b0, 8'h11, rd, er, lat);
        @(negedge clk);
        req = 1'b1; addr = 16'h0020; mem_rw = 1'b0; wdata = 8'h77;
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (rdy) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (rdy) pulses++;
        end
        check("abort_no_rdy", 16'(pulses), 16'd0);
        check("abort_io_out_rst", 16'(io_out), 16'h00);
        xfer(16'h0020, 1'b1, 8'h00, rd, er, lat);
        check("abort_no_commit", 16'(rd), 16'h11);
        check("abort_rd_lat", 16'(lat), 16'(LAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
